shift_right_seq: RTL and testbench

Multi-cycle right-shift unit providing SRL/SRAI-style logical and arithmetic right shifts for the integer datapath. It is the right-shift counterpart to the combinational left barrel shifter. It resolves one shift-amount bit per cycle, LSB first, through a 5-stage iterative log shifter, and uses valid/ready handshakes on both sides. Its fixed latency lets the ALU issue a shift and collect the result without a wide combinational right-shift path.

---
 rtl/shift_right_seq.sv | 118 +++++++++++
 tb/tb_shift_right_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// ---------------------------------------------------------------------------
// shift_right_seq
//
// Multi-cycle 32-bit right shifter (logical or arithmetic). It resolves one
// shift-amount bit per cycle, LSB first, through five log-shifter stages, and
// uses valid/ready handshakes on both sides.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (state IDLE)
//   data_in    in   32-bit operand
//   shamt      in   5-bit shift amount
//   arith      in   1 = sign fill, 0 = zero fill
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer accepts result
//   data_out   out  shifted result, held until the next result replaces it
//   busy       out  request in flight (SHIFT or DONE)
// ---------------------------------------------------------------------------
module shift_right_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_w;         // working operand, shifted in place
  logic [4:0]  r_a;         // latched shift amount
  logic        r_f;         // fill bit, taken from the operand sign at accept
  logic [2:0]  r_k;         // current stage, 0..4
  logic [31:0] r_data_out;  // result register, survives the output handshake

  // Candidate result of every stage: stage gi shifts by 2**gi, filling with r_f.
  logic [31:0] w_stage [5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign w_stage[gi] = {{SH{r_f}}, r_w[31:SH]};
    end
  endgenerate

  // Apply the stage selected by r_k only when its shift-amount bit is set.
  logic [31:0] w_step;

  always_comb begin
    w_step = r_w;
    case (r_k)
      3'd0:    if (r_a[0]) w_step = w_stage[0];
      3'd1:    if (r_a[1]) w_step = w_stage[1];
      3'd2:    if (r_a[2]) w_step = w_stage[2];
      3'd3:    if (r_a[3]) w_step = w_stage[3];
      3'd4:    if (r_a[4]) w_step = w_stage[4];
      default: w_step = r_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_a        <= '0;
      r_f        <= 1'b0;
      r_k        <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_w     <= data_in;
            r_a     <= shamt;
            r_f     <= arith & data_in[31];
            r_k     <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // All five stages always run, so latency does not depend on shamt.
          r_w <= w_step;
          r_k <= r_k + 3'd1;
          if (r_k == 3'd4) begin
            r_data_out <= w_step;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register, so out_valid
  // never depends combinationally on out_ready.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_right_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .shamt    (shamt),
    .arith    (arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  // Wait (bounded) for out_valid; returns cycles elapsed. Scrambles the
  // request inputs while waiting to show they are ignored.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      data_in = $urandom;
      shamt   = 5'($urandom);
      arith   = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input logic [31:0] exp, input int stall);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    data_in  = d;
    shamt    = s;
    arith    = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_result"}, data_out, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_data"}, data_out, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, data_out, exp);
    $display("%s: data=0x%08h shamt=%0d arith=%0d result=0x%08h expected=0x%08h stall=%0d",
             tag, d, s, a, data_out, exp, stall);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] d;
    logic [4:0]  s;
    logic        a;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    data_in = 32'hCAFEF00D; shamt = 5'd3; arith = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // First cycle after reset: in_valid held during reset must not have been taken.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    in_valid = 1'b0;

    // Directed cases.
    run_op("lsr4",     32'h80000000, 5'd4,  1'b0, 32'h08000000, 0);
    run_op("asr4",     32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1);
    run_op("asr31",    32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 0);
    run_op("lsr31",    32'h80000000, 5'd31, 1'b0, 32'h00000001, 0);
    run_op("asr31pos", 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 0);
    run_op("sh0",      32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF, 2);
    run_op("isolate",  32'h12345678, 5'd8,  1'b0, 32'h00123456, 0);

    // Backpressure: result held 10 cycles while a new request is offered.
    in_valid = 1'b1; data_in = 32'hF0000000; shamt = 5'd2; arith = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd5);
    in_valid = 1'b1; data_in = 32'h00000F00; shamt = 5'd8; arith = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_data", data_out, 32'hFC000000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accept", 32'(busy), 32'd1);
    wait_valid(lat);
    check("bp_new_latency", 32'(lat), 32'd5);
    check("bp_new_result", data_out, 32'h0000000F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("backpressure: second result=0x%08h", data_out);

    // Reset in the middle of a shift.
    in_valid = 1'b1; data_in = 32'hA5A5A5A5; shamt = 5'd5; arith = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    $display("reset_abort: stray results=%0d", seen);
    run_op("post_abort", 32'h80000010, 5'd4, 1'b1, 32'hF8000001, 0);

    // Random back-to-back traffic with random consumer stalls.
    for (int t = 0; t < 1000; t++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom);
      run_op($sformatf("rnd%0d", t), d, s, a, ref_shift(d, int'(s), a),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
